// File: rtl/vector_loader.sv
`default_nettype none
// ============================================================================
// Module   : vector_loader
// Brief    : Packs a valid/ready sample stream into an NINPUTS-entry vector,
//            launches the adder tree with a one-cycle go and holds the vector
//            until outReady. Define VECTOR_LOADER_DBUF_EN for a shadow bank.
// Revision : 1.0 - initial release
// ============================================================================
module vector_loader #(
    parameter int NINPUTS = 1024,
    parameter int IWIDTH  = 8,
    parameter int CWIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [IWIDTH-1:0]                in_data,
    input  logic                             in_last,
    output logic [NINPUTS-1:0][IWIDTH-1:0]   vec,
    output logic                             go,
    input  logic                             tree_ready,
    output logic                             short_err,
    output logic [CWIDTH-1:0]                frame_cnt
);

    localparam int               c_IW   = $clog2(NINPUTS);
    localparam logic [c_IW-1:0]  c_LAST = c_IW'(NINPUTS - 1);
    localparam logic [c_IW-1:0]  c_ONE  = c_IW'(1);

    typedef enum logic [1:0] {
        S_FILL   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic [c_IW-1:0]                 r_idx;
    logic                            r_live;
    logic                            r_short;
    logic [CWIDTH-1:0]               r_frame;

    logic                            w_xfer;
    logic                            w_at_end;
    logic                            w_close;
    logic [NINPUTS-1:0]              w_we;
    logic [NINPUTS-1:0][IWIDTH-1:0]  w_wd;

    assign w_xfer    = in_valid & in_ready;
    assign w_at_end  = (r_idx == c_LAST);
    assign w_close   = w_xfer & (w_at_end | in_last);
    assign go        = (r_state == S_LAUNCH);
    assign short_err = r_short;
    assign frame_cnt = r_frame;

    // A closing in_last writes the sample and zero-pads every higher entry in one edge
    generate
        for (genvar k = 0; k < NINPUTS; k++) begin : g_entry
            localparam logic [c_IW-1:0] c_K = c_IW'(k);
            assign w_we[k] = w_xfer & ((c_K == r_idx) | (in_last & (c_K > r_idx)));
            assign w_wd[k] = (c_K == r_idx) ? in_data : '0;
        end
    endgenerate

`ifdef VECTOR_LOADER_DBUF_EN
    logic [1:0][NINPUTS-1:0][IWIDTH-1:0] r_bank;
    logic                                r_active;
    logic                                r_full;
    logic                                w_wsel;
    logic                                w_full_nxt;
    logic                                w_swap;

    // FILL writes the active bank; WAIT writes the shadow bank behind the tree
    assign w_wsel     = (r_state == S_FILL) ? r_active : ~r_active;
    assign w_full_nxt = r_full | w_close;
    assign w_swap     = (r_state == S_WAIT) & tree_ready &
                        (r_full | w_xfer | (r_idx != '0));
    assign in_ready   = r_live & ((r_state == S_FILL) |
                                  ((r_state == S_WAIT) & ~r_full));
    assign vec        = r_bank[r_active];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bank   <= '0;
            r_active <= 1'b0;
            r_full   <= 1'b0;
        end else begin
            for (int k = 0; k < NINPUTS; k++) begin
                if (w_we[k]) begin
                    r_bank[w_wsel][k] <= w_wd[k];
                end
            end
            if (w_swap) begin
                r_active <= ~r_active;
            end
            if (r_state == S_WAIT) begin
                if (tree_ready) begin
                    r_full <= 1'b0;
                end else if (w_close) begin
                    r_full <= 1'b1;
                end
            end
        end
    end
`else
    logic [NINPUTS-1:0][IWIDTH-1:0] r_vec;

    assign in_ready = r_live & (r_state == S_FILL);
    assign vec      = r_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vec <= '0;
        end else begin
            for (int k = 0; k < NINPUTS; k++) begin
                if (w_we[k]) begin
                    r_vec[k] <= w_wd[k];
                end
            end
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_close) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tree_ready) begin
`ifdef VECTOR_LOADER_DBUF_EN
                    w_state_nxt = w_full_nxt ? S_LAUNCH : S_FILL;
`else
                    w_state_nxt = S_FILL;
`endif
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // r_live keeps in_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FILL;
            r_idx   <= '0;
            r_live  <= 1'b0;
            r_short <= 1'b0;
            r_frame <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
            r_short <= w_xfer & in_last & ~w_at_end;
            if (w_xfer) begin
                r_idx <= w_close ? '0 : (r_idx + c_ONE);
            end
            if (r_state == S_LAUNCH) begin
                r_frame <= r_frame + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_loader
// Brief    : Self-checking bench for vector_loader (NINPUTS=8, IWIDTH=8) with
//            a latency-programmable adder-tree model and a sample-queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_loader;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int CW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_last = 1'b0;
    logic [W-1:0]         in_data = '0;
    logic                 tree_ready = 1'b0;
    logic                 in_ready;
    logic                 go;
    logic                 short_err;
    logic [N-1:0][W-1:0]  vec;
    logic [CW-1:0]        frame_cnt;

    always #5 clk = ~clk;

    vector_loader #(.NINPUTS(N), .IWIDTH(W), .CWIDTH(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .vec        (vec),
        .go         (go),
        .tree_ready (tree_ready),
        .short_err  (short_err),
        .frame_cnt  (frame_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: pending samples, completed vectors, tree occupancy
    bit          m_live = 0, m_go = 0, m_short = 0, m_busy = 0, m_ready = 0;
    int          m_frame = 0;
    logic [7:0]  cur[$];
    logic [63:0] done_q[$];
    logic [63:0] launch_q[$];

    int          tree_lat = 4;
    int          tcnt = 0, cyc_n = 0, tr_cyc = 0, go_gap = 0;
    int          last_sum = 0, prev_sum = 0;
    logic [63:0] last_vec = '0;
    bit          prev_go = 0;
    bit          saw_short = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack_cur();
        logic [63:0] r = '0;
        for (int k = 0; k < cur.size(); k++) r[k*8 +: 8] = cur[k];
        return r;
    endfunction

    task automatic model_reset();
        m_live = 0; m_go = 0; m_short = 0; m_busy = 0; m_ready = 0; m_frame = 0;
        cur.delete(); done_q.delete(); launch_q.delete();
    endtask

    task automatic model_step(input bit acc, input logic [7:0] d, input bit l, input bit tr);
        bit go_now;
        go_now = m_go;
        if (go_now) begin
            m_busy  = 1;
            m_frame = (m_frame + 1) % 65536;
        end
        m_short = 0;
        if (acc) begin
            m_short = l && (cur.size() < N - 1);
            cur.push_back(d);
            if (l || cur.size() == N) begin
                done_q.push_back(pack_cur());
                cur.delete();
            end
        end
        if (tr && m_busy && !go_now) m_busy = 0;
        m_go = 0;
        if (!m_busy && done_q.size() != 0) begin
            m_go = 1;
            launch_q.push_back(done_q.pop_front());
        end
        m_live = 1;
`ifdef VECTOR_LOADER_DBUF_EN
        m_ready = !m_go && (done_q.size() == 0);
`else
        m_ready = !m_go && !m_busy;
`endif
    endtask

    // One clock: check outputs at negedge, drive, model the posedge
    task automatic cyc(input bit v, input logic [7:0] d, input bit l, output bit acc);
        chk("in_ready", in_ready, m_ready);
        chk("go", go, m_go);
        chk("short_err", short_err, m_short);
        chk("frame_cnt", frame_cnt, m_frame);
        if (short_err) saw_short = 1;
        in_valid = v; in_data = d; in_last = l;
        @(posedge clk);
        acc = v && m_ready;
        if (!rst) model_reset();
        else      model_step(acc, d, l, tree_ready);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        bit acc = 0;
        int b = 0;
        while (!acc && b < 64) begin
            cyc(1'b1, d, l, acc);
            b++;
        end
        if (!acc) chk("send_timeout", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        int b = 0;
        while ((m_busy || m_go || done_q.size() != 0) && b < 200) begin
            cyc(1'b0, 8'h00, 1'b0, acc);
            b++;
        end
        chk("drain_timeout", b < 200, 1);
        cyc(1'b0, 8'h00, 1'b0, acc);
    endtask

    // Adder-tree model: latches vec on go, reports outReady tree_lat cycles later
    always @(negedge clk) begin
        cyc_n++;
        if (!rst) begin
            tcnt = 0; tree_ready = 0; prev_go = 0;
        end else begin
            tree_ready = 0;
            if (go) begin
                chk("go_while_busy", (tcnt != 0) || prev_go, 0);
                if (launch_q.size() == 0) chk("unexpected_go", go, 0);
                else                      chk("vec_at_go", vec, launch_q.pop_front());
                prev_sum = last_sum;
                last_sum = 0;
                for (int k = 0; k < N; k++) last_sum += $signed(vec[k]);
                last_vec = vec;
                go_gap   = cyc_n - tr_cyc;
                tcnt     = tree_lat;
            end else if (tcnt > 0) begin
                tcnt--;
                if (tcnt == 0) begin
                    tree_ready = 1;
                    tr_cyc     = cyc_n;
                end
            end
            prev_go = go;
        end
    end

    typedef struct {
        int         n;
        logic [7:0] d[8];
        bit         lst;
        bit         exp_short;
        int         exp_sum;
    } rec_t;

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rec_t tbl[6];
        bit   acc;
        int   b;

        tbl[0].n = 8; tbl[0].d = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        tbl[0].lst = 1; tbl[0].exp_short = 0; tbl[0].exp_sum = 36;
        tbl[1].n = 3; tbl[1].d = '{8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[1].lst = 1; tbl[1].exp_short = 1; tbl[1].exp_sum = 18;
        tbl[2].n = 8; tbl[2].d = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
        tbl[2].lst = 0; tbl[2].exp_short = 0; tbl[2].exp_sum = 1016;
        tbl[3].n = 1; tbl[3].d = '{8'hFB, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        tbl[3].lst = 1; tbl[3].exp_short = 1; tbl[3].exp_sum = -5;
        tbl[4].n = 8; tbl[4].d = '{8'hFF, 8'd2, 8'hFD, 8'd4, 8'hFB, 8'd6, 8'hF9, 8'd8};
        tbl[4].lst = 1; tbl[4].exp_short = 0; tbl[4].exp_sum = 4;
        tbl[5].n = 7; tbl[5].d = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd0};
        tbl[5].lst = 1; tbl[5].exp_short = 1; tbl[5].exp_sum = 280;

        // Reset held with in_valid asserted
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'h55, 1'b0, acc);
        chk("reset_vec", vec, 64'h0);
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, acc);
        chk("ready_after_release", in_ready, 1);

        for (int i = 0; i < 6; i++) begin
            saw_short = 0;
            last_sum  = 32'h7fffffff;
            for (int j = 0; j < tbl[i].n; j++) send(tbl[i].d[j], tbl[i].lst && (j == tbl[i].n - 1));
            drain();
            chk($sformatf("tbl%0d_sum", i), last_sum, tbl[i].exp_sum);
            chk($sformatf("tbl%0d_short", i), saw_short, tbl[i].exp_short);
        end

        // -128 vector, then 99 held valid while the tree is busy
        for (int j = 0; j < N; j++) send(8'h80, j == N - 1);
        acc = 0; b = 0;
        while (!acc && b < 50) begin
            chk("vec_hold", vec, {8{8'h80}});
            cyc(1'b1, 8'd99, 1'b0, acc);
            b++;
        end
        chk("hold_accept", acc, 1);
        chk("sum_neg", last_sum, -1024);
        chk("vec0_99", vec[0], 8'd99);
        chk("vec_rest", vec[7:1], {7{8'h80}});
        send(8'd1, 1'b1);
        drain();

        // Asynchronous reset in the middle of a vector
        for (int j = 0; j < 4; j++) send(8'(11 * (j + 1)), 1'b0);
        #2 rst = 1'b0;
        #1;
        chk("rst_vec", vec, 64'h0);
        chk("rst_ready", in_ready, 0);
        chk("rst_go", go, 0);
        chk("rst_frame", frame_cnt, 0);
        chk("rst_short", short_err, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int j = 0; j < N; j++) send(8'(j + 1), j == N - 1);
        drain();
        chk("frame_after_rst", frame_cnt, 1);
        chk("vec_after_rst", last_vec, 64'h0807060504030201);

        // Sixteen samples back to back
`ifdef VECTOR_LOADER_DBUF_EN
        tree_lat = 12;
`endif
        for (int j = 0; j < 2 * N; j++) send(8'(j + 1), (j % N) == N - 1);
        drain();
        chk("stream_sum1", prev_sum, 36);
        chk("stream_sum2", last_sum, 100);
`ifdef VECTOR_LOADER_DBUF_EN
        chk("dbuf_go_gap", go_gap, 1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            if (i % 40 == 0) tree_lat = $urandom_range(1, 12);
            cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
